// File: rtl/uart_word_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_word_tx_if : word write handshake into the UART word transmitter    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface uart_word_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              wr_ready;

  modport master (output data_in, output wr_en, input  wr_ready);
  modport slave  (input  data_in, input  wr_en, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/uart_word_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_word_tx : sends a word as NBYTES back-to-back 8N1 frames, with one  |
// | pending word buffered behind the word currently shifting out.  Rev 1.0   |
// +--------------------------------------------------------------------------+
module uart_word_tx #(
  parameter int NBYTES    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic       clk_50m,
  input  wire logic       rst,
  input  wire logic       clken,
  uart_word_tx_if.slave   wr,
  output logic            Tx,
  output logic            Tx_busy,
  output logic            done
);

  localparam int DATA_W = 8 * NBYTES;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] pending;
  logic [DATA_W-1:0] word;
  logic [BW-1:0]     byte_idx;
  logic [2:0]        bit_idx;
  logic [7:0]        cur_byte;
  logic              last_byte;
  logic              accept;
  logic              consume;

  // The byte on the line is always at the sending end of the shift register.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_byte = word[DATA_W-1 -: 8];
    end else begin : g_lsb_first
      assign cur_byte = word[7:0];
    end
  endgenerate

  assign last_byte = (byte_idx == BW'(NBYTES - 1));
  assign accept    = wr.wr_en && wr.wr_ready;
  assign consume   = ((state == IDLE) && !wr.wr_ready) ||
                     ((state == STOP) && clken && last_byte && !wr.wr_ready);
  assign Tx_busy   = (state != IDLE);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      Tx          <= 1'b1;
      done        <= 1'b0;
      wr.wr_ready <= 1'b1;
      pending     <= '0;
      word        <= '0;
      byte_idx    <= '0;
      bit_idx     <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        pending <= wr.data_in;
      end
      // Pending slot is read out before a same-edge capture refills it.
      wr.wr_ready <= !(((!wr.wr_ready) && !consume) || accept);

      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (!wr.wr_ready) begin
            word     <= pending;
            byte_idx <= '0;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (clken) begin
            Tx       <= 1'b0;
            byte_idx <= '0;
            state    <= START;
          end
        end
        START: begin
          if (clken) begin
            Tx      <= cur_byte[0];
            bit_idx <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (clken) begin
            if (bit_idx == 3'd7) begin
              Tx    <= 1'b1;
              state <= STOP;
            end else begin
              Tx      <= cur_byte[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (clken) begin
            if (!last_byte) begin
              Tx       <= 1'b0;
              byte_idx <= byte_idx + BW'(1);
              word     <= MSB_FIRST ? (word << 8) : (word >> 8);
              state    <= START;
            end else begin
              done <= 1'b1;
              if (!wr.wr_ready) begin
                Tx       <= 1'b0;
                word     <= pending;
                byte_idx <= '0;
                state    <= START;
              end else begin
                Tx    <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        default: begin
          Tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_word_tx : MSB-first and LSB-first instances against a bit-list   |
// | model of the serial line.  Rev 1.0                                       |
// +--------------------------------------------------------------------------+
module tb_uart_word_tx;

  logic clk_50m = 1'b0;
  logic rst     = 1'b1;
  logic clken   = 1'b0;
  always #5 clk_50m = ~clk_50m;

  uart_word_tx_if #(.DATA_W(32)) bm ();
  uart_word_tx_if #(.DATA_W(32)) bl ();
  assign bl.data_in = bm.data_in;
  assign bl.wr_en   = bm.wr_en;

  logic tx_m, busy_m, done_m, tx_l, busy_l, done_l;

  uart_word_tx #(.NBYTES(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .wr(bm.slave),
    .Tx(tx_m), .Tx_busy(busy_m), .done(done_m));
  uart_word_tx #(.NBYTES(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .wr(bl.slave),
    .Tx(tx_l), .Tx_busy(busy_l), .done(done_l));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line model: each accepted word expands to its full list of line bits.
  logic        mq [2][$];
  logic [31:0] mpend [2];
  bit          mpv [2]   = '{0, 0};
  bit          mbusy [2] = '{0, 0};
  logic        mtx [2]   = '{1'b1, 1'b1};
  logic        mdone [2] = '{1'b0, 1'b0};

  task automatic push_word(input int k, input logic [31:0] w);
    int         idx;
    logic [7:0] by;
    for (int b = 0; b < 4; b++) begin
      idx = (k == 0) ? (3 - b) : b;
      by  = w[8*idx +: 8];
      mq[k].push_back(1'b0);
      for (int i = 0; i < 8; i++) mq[k].push_back(by[i]);
      mq[k].push_back(1'b1);
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic ck,
                            input logic we, input logic [31:0] d);
    bit acc;
    if (r) begin
      mq[k].delete(); mpv[k] = 0; mbusy[k] = 0; mtx[k] = 1'b1; mdone[k] = 1'b0;
      return;
    end
    mdone[k] = 1'b0;
    acc = we && !mpv[k];
    if (mbusy[k]) begin
      if (ck) begin
        if (mq[k].size() > 0) mtx[k] = mq[k].pop_front();
        else begin
          mdone[k] = 1'b1;
          if (mpv[k]) begin
            push_word(k, mpend[k]); mpv[k] = 0; mtx[k] = mq[k].pop_front();
          end else begin
            mbusy[k] = 0; mtx[k] = 1'b1;
          end
        end
      end
    end else if (mpv[k]) begin
      push_word(k, mpend[k]); mpv[k] = 0; mbusy[k] = 1;
    end
    if (acc) begin
      mpend[k] = d; mpv[k] = 1;
    end
  endtask

  // Line log: value on Tx after every clken edge seen while busy.
  logic lg [2][$];
  int   dck [2][$];
  int   ndone [2] = '{0, 0};
  bit   pbusy [2] = '{0, 0};
  int   drop = 0, cyc = 0, ckcnt = 0, start_cyc = 0, done_cyc = 0;

  function automatic logic [9:0] frame(input int k, input int base);
    logic [9:0] f;
    for (int i = 0; i < 10; i++) f[i] = (base + i < lg[k].size()) ? lg[k][base+i] : 1'bx;
    return f;
  endfunction

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      lg[k].delete(); dck[k].delete(); ndone[k] = 0;
    end
    drop = 0;
  endtask

  initial begin : mon
    logic r_s, ck_s, we_s, t, b, d, rd;
    logic [31:0] d_s;
    forever begin
      @(posedge clk_50m);
      cyc++;
      r_s = rst; ck_s = clken; we_s = bm.wr_en; d_s = bm.data_in;
      if (!r_s && ck_s) ckcnt++;
      for (int k = 0; k < 2; k++) model_step(k, r_s, ck_s, we_s, d_s);
      #1;
      for (int k = 0; k < 2; k++) begin
        t  = k ? tx_l : tx_m;
        b  = k ? busy_l : busy_m;
        d  = k ? done_l : done_m;
        rd = k ? bl.wr_ready : bm.wr_ready;
        chk($sformatf("tx%0d", k), t, mtx[k]);
        chk($sformatf("busy%0d", k), b, mbusy[k]);
        chk($sformatf("done%0d", k), d, mdone[k]);
        chk($sformatf("ready%0d", k), rd, !mpv[k]);
        if (!r_s) begin
          if (ck_s && pbusy[k]) begin
            lg[k].push_back(t);
            if (k == 0 && lg[0].size() == 1) start_cyc = cyc;
          end
          if (d) begin
            ndone[k]++;
            dck[k].push_back(ckcnt);
            if (k == 0) done_cyc = cyc;
          end
          if (k == 0 && ndone[0] == 1 && !b) drop++;
        end
        pbusy[k] = b;
      end
    end
  end

  int div = 3, cnt = 0;
  bit rnd_ck = 0;
  initial begin : ckgen
    forever begin
      @(negedge clk_50m);
      if (rnd_ck) clken = ($urandom_range(0, 2) == 0);
      else if (div <= 1) clken = 1'b1;
      else begin
        clken = (cnt == 0);
        cnt   = (cnt + 1) % div;
      end
    end
  end

  task automatic write_word(input logic [31:0] w);
    bm.wr_en = 1'b1; bm.data_in = w;
    @(negedge clk_50m);
    bm.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_m || !bm.wr_ready) && n < budget) begin
      @(negedge clk_50m); n++;
    end
    chk("idle_timeout", (n < budget), 1);
    @(negedge clk_50m);
  endtask

  initial begin : main
    logic [31:0] w;
    int n;
    bm.wr_en = 1'b0; bm.data_in = '0;
    repeat (3) @(negedge clk_50m);
    chk("rst_tx", tx_m, 1); chk("rst_busy", busy_m, 0);
    chk("rst_ready", bm.wr_ready, 1); chk("rst_done", done_m, 0);
    rst = 1'b0;

    // Single word, both byte orders
    clear_logs(); write_word(32'hABCE2135); wait_idle(2000);
    chk("t1_frame_ab", frame(0, 0), 10'b1101010110);
    chk("t1_frame_ce", frame(0, 10), 10'b1110011100);
    chk("t1_len", lg[0].size(), 41);
    chk("t1_ndone", ndone[0], 1);
    chk("t2_frame_35", frame(1, 0), 10'b1001101010);
    chk("t2_frame_ab", frame(1, 30), 10'b1101010110);

    // Second word written while busy follows with no idle gap
    clear_logs(); write_word(32'h00000001);
    repeat (12) @(negedge clk_50m);
    chk("t3_busy", busy_m, 1);
    write_word(32'hFFFFFFFF); wait_idle(4000);
    chk("t3_ndone", ndone[0], 2);
    chk("t3_gap", (dck[0].size() > 1) ? dck[0][1] - dck[0][0] : -1, 40);
    chk("t3_drop", drop, 0);
    chk("t3_frame_ff", frame(0, 40), 10'b1111111110);

    // Third write while pending is full is dropped
    clear_logs(); write_word(32'h5A5A0F0F);
    repeat (3) @(negedge clk_50m);
    write_word(32'hC3C31111);
    chk("t4_ready_low", bm.wr_ready, 0);
    write_word(32'h99999999); wait_idle(4000);
    chk("t4_ndone", ndone[0], 2);
    chk("t4_len", lg[0].size(), 81);
    chk("t4_frame_a", frame(0, 0), 10'b1010110100);
    chk("t4_frame_b", frame(0, 40), 10'b1110000110);

    // Asynchronous reset in the middle of byte 2
    clear_logs(); div = 2; write_word(32'hCAFEF00D);
    n = 0;
    while (lg[0].size() < 27 && n < 3000) begin
      @(negedge clk_50m); n++;
    end
    chk("t5_reach", (n < 3000), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_tx", tx_m, 1); chk("t5_async_busy", busy_m, 0);
    chk("t5_async_ready", bm.wr_ready, 1); chk("t5_async_busy_l", busy_l, 0);
    @(negedge clk_50m); @(negedge clk_50m);
    rst = 1'b0;
    clear_logs(); write_word(32'h12345678); wait_idle(2000);
    chk("t5_frame_12", frame(0, 0), 10'b1000100100);
    chk("t5_frame_78", frame(1, 0), 10'b1011110000);
    chk("t5_len", lg[0].size(), 41);

    // clken held high: one bit per clock
    clear_logs(); div = 1; w = $urandom; write_word(w); wait_idle(500);
    chk("t6_len", lg[0].size(), 41);
    chk("t6_cycles", done_cyc - start_cyc, 40);
    chk("t6_frame_m", frame(0, 0), {1'b1, w[31:24], 1'b0});
    chk("t6_frame_l", frame(1, 0), {1'b1, w[7:0], 1'b0});

    // Random writes and random baud strobes
    rnd_ck = 1;
    repeat (4000) begin
      @(negedge clk_50m);
      bm.wr_en   = ($urandom_range(0, 15) == 0);
      bm.data_in = $urandom;
    end
    bm.wr_en = 1'b0;
    wait_idle(5000);
    rnd_ck = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
